// File: rtl/ringosc_freq_monitor.sv
// ringosc_freq_monitor
//   UART command/measurement controller for a bank of adjustable ring
//   oscillators. Single-byte commands select a channel, step or clear its
//   tap setting (pulsing that channel's oscillator reset), and start a
//   frequency measurement. The result goes back over the UART.
//
//   Optional build macro RINGOSC_MON_HEX_EN: the result is sent as
//   COUNT_W/4 uppercase ASCII hex digits followed by 0x0A. Without it, the
//   result is sent as COUNT_W/8 raw bytes. Both orders are MSB first.
//
// Ports
//   clk, rst_n   system clock, async active-low reset
//   osc_in       ring oscillator outputs (async to clk)
//   osc_rst      per-channel oscillator reset (all ones while in reset)
//   tap          packed tap selects, channel c at [c*TAP_W +: TAP_W]
//   rx_valid/rx_byte            received command byte
//   tx_start/tx_byte/tx_busy    UART transmit handshake
//   meas_count/meas_valid       last measurement and its update strobe
module ringosc_freq_monitor #(
    parameter int CHANNELS      = 4,
    parameter int MAX_TAPS      = 16,
    parameter int PRESCALE_BITS = 4,
    parameter int GATE_CYCLES   = 32000,
    parameter int COUNT_W       = 24,
    localparam int TAP_W        = $clog2(MAX_TAPS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       osc_in,
    output logic [CHANNELS-1:0]       osc_rst,
    output logic [CHANNELS*TAP_W-1:0] tap,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_byte,
    output logic                      tx_start,
    output logic [7:0]                tx_byte,
    input  logic                      tx_busy,
    output logic [COUNT_W-1:0]        meas_count,
    output logic                      meas_valid
);
    localparam int SEL_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int GATE_W = $clog2(GATE_CYCLES + 1);
`ifdef RINGOSC_MON_HEX_EN
    localparam int NSEND  = COUNT_W/4 + 1;
`else
    localparam int NSEND  = COUNT_W/8;
`endif
    localparam int IDX_W  = $clog2(NSEND + 1);
    localparam logic [7:0]       CH8     = 8'(CHANNELS);
    localparam logic [TAP_W-1:0] TAP_MAX = TAP_W'(MAX_TAPS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ECHO, S_GATE, S_SEND} state_t;
    typedef enum logic [1:0] {TX_FREE, TX_BUSY, TX_DONE} txph_t;

    state_t                         state_q, state_d;
    txph_t                          txph_q;
    logic [CHANNELS-1:0][TAP_W-1:0] tap_q;
    logic [SEL_W-1:0]               sel_q, sel_new;
    logic [TAP_W-1:0]               cur_tap, tap_new;
    logic [7:0]                     echo_q, echo_d, send_byte;
    logic [COUNT_W-1:0]             cnt_q, cnt_inc;
    logic [GATE_W-1:0]              gate_q;
    logic [IDX_W-1:0]               idx_q;
    logic                           tap_upd, sel_upd, start_gate, byte_done;
    logic [CHANNELS-1:0]            div_msb;
    logic [2:0]                     sync_q;
    logic                           rise;

    assign tap = tap_q;

    // Per-channel ripple divider in the oscillator domain. Each stage toggles
    // on the falling edge of the previous one; osc_rst clears the whole chain.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        for (genvar k = 0; k < PRESCALE_BITS; k++) begin : g_bit
            logic q;
            if (k == 0) begin : g_first
                always_ff @(posedge osc_in[c] or posedge osc_rst[c])
                    if (osc_rst[c]) q <= 1'b0;
                    else            q <= ~q;
            end else begin : g_next
                always_ff @(negedge g_bit[k-1].q or posedge osc_rst[c])
                    if (osc_rst[c]) q <= 1'b0;
                    else            q <= ~q;
            end
        end
        assign div_msb[c] = g_bit[PRESCALE_BITS-1].q;
    end

    // Only the selected channel is brought into clk; sync_q[0..1] form the
    // synchronizer and sync_q[2] is the edge-detect history.
    assign rise    = sync_q[1] & ~sync_q[2];
    assign cnt_inc = (rise && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    assign cur_tap = tap_q[sel_q];
    assign byte_done = (txph_q == TX_DONE) && !tx_busy;

    always_comb begin
        send_byte = 8'h00;
`ifdef RINGOSC_MON_HEX_EN
        if (int'(idx_q) == NSEND - 1) begin
            send_byte = 8'h0A;
        end else begin
            logic [3:0] nib;
            nib = 4'(meas_count >> (4 * (COUNT_W/4 - 1 - int'(idx_q))));
            send_byte = (nib < 4'd10) ? 8'h30 + 8'(nib) : 8'h37 + 8'(nib);
        end
`else
        send_byte = 8'(meas_count >> (8 * (NSEND - 1 - int'(idx_q))));
`endif
    end

    always_comb begin
        state_d    = state_q;
        tap_upd    = 1'b0;
        tap_new    = cur_tap;
        sel_upd    = 1'b0;
        sel_new    = sel_q;
        echo_d     = echo_q;
        start_gate = 1'b0;
        case (state_q)
            S_IDLE: if (rx_valid) begin
                case (rx_byte)
                    8'h5D: begin
                        tap_upd = 1'b1;
                        tap_new = (cur_tap == TAP_MAX) ? cur_tap : cur_tap + 1'b1;
                    end
                    8'h5B: begin
                        tap_upd = 1'b1;
                        tap_new = (cur_tap == '0) ? cur_tap : cur_tap - 1'b1;
                    end
                    8'h72: begin
                        tap_upd = 1'b1;
                        tap_new = '0;
                    end
                    8'h6D: begin
                        start_gate = 1'b1;
                        state_d    = S_GATE;
                    end
                    default: if (rx_byte >= 8'h30 && rx_byte <= 8'h39 &&
                                 (rx_byte - 8'h30) < CH8) begin
                        sel_upd = 1'b1;
                        sel_new = SEL_W'(rx_byte - 8'h30);
                        echo_d  = rx_byte;
                        state_d = S_ECHO;
                    end
                endcase
                if (tap_upd) begin
                    echo_d  = 8'h21 + 8'(tap_new);
                    state_d = S_ECHO;
                end
            end
            S_ECHO: if (byte_done) state_d = S_IDLE;
            S_GATE: if (gate_q == '0) state_d = S_SEND;
            S_SEND: if (byte_done && idx_q == IDX_W'(NSEND - 1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txph_q     <= TX_FREE;
            tap_q      <= '0;
            sel_q      <= '0;
            echo_q     <= 8'h00;
            osc_rst    <= '1;
            cnt_q      <= '0;
            gate_q     <= '0;
            idx_q      <= '0;
            sync_q     <= '0;
            meas_count <= '0;
            meas_valid <= 1'b0;
            tx_start   <= 1'b0;
            tx_byte    <= 8'h00;
        end else begin
            tx_start   <= 1'b0;
            meas_valid <= 1'b0;
            osc_rst    <= '0;
            echo_q     <= echo_d;
            sync_q     <= {sync_q[1:0], div_msb[sel_q]};
            if (tap_upd) begin
                tap_q[sel_q]   <= tap_new;
                osc_rst[sel_q] <= 1'b1;
            end
            if (sel_upd) sel_q <= sel_new;
            if (start_gate) begin
                cnt_q  <= '0;
                gate_q <= GATE_W'(GATE_CYCLES - 1);
            end
            if (state_q == S_GATE) begin
                cnt_q  <= cnt_inc;
                gate_q <= gate_q - 1'b1;
                if (gate_q == '0) begin
                    meas_count <= cnt_inc;
                    meas_valid <= 1'b1;
                    idx_q      <= '0;
                end
            end
            if (state_q == S_ECHO || state_q == S_SEND) begin
                case (txph_q)
                    TX_FREE: if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_byte  <= (state_q == S_ECHO) ? echo_q : send_byte;
                        txph_q   <= TX_BUSY;
                    end
                    TX_BUSY: if (tx_busy) txph_q <= TX_DONE;
                    default: if (!tx_busy) begin
                        txph_q <= TX_FREE;
                        if (state_q == S_SEND) idx_q <= idx_q + 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ringosc_freq_monitor.sv
`timescale 1ns/1ps
module tb_ringosc_freq_monitor;
    localparam int CH = 4, TW = 4, GATE = 1000, CW = 24;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [CH-1:0]   osc_in = '0;
    logic [CH-1:0]   osc_rst;
    logic [CH*TW-1:0] tap;
    logic            rx_valid;
    logic [7:0]      rx_byte;
    logic            tx_start;
    logic [7:0]      tx_byte;
    logic            tx_busy = 1'b0;
    logic [CW-1:0]   meas_count;
    logic            meas_valid;

    ringosc_freq_monitor #(.CHANNELS(CH), .MAX_TAPS(16), .PRESCALE_BITS(4),
                           .GATE_CYCLES(GATE), .COUNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .osc_rst(osc_rst), .tap(tap),
        .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_start(tx_start),
        .tx_byte(tx_byte), .tx_busy(tx_busy), .meas_count(meas_count),
        .meas_valid(meas_valid));

    initial forever #15.625 clk = ~clk;           // 32 MHz
    initial forever #5.0    osc_in[1] = ~osc_in[1]; // 100 MHz
    initial forever #7.0    osc_in[0] = ~osc_in[0];
    initial forever #6.1    osc_in[2] = ~osc_in[2];
    initial forever #9.3    osc_in[3] = ~osc_in[3];

    // UART model and monitors
    logic [7:0] txq[$];
    int ts_cnt = 0, ts_wide = 0, mv_cnt = 0, busy_left = 0;
    logic ts_prev = 1'b0;
    logic [CH-1:0] rst_prev = '0;
    int rst_hi[CH], rst_rise[CH];
    initial for (int c = 0; c < CH; c++) begin rst_hi[c] = 0; rst_rise[c] = 0; end

    always @(negedge clk) begin
        if (tx_start) begin
            txq.push_back(tx_byte);
            ts_cnt++;
            if (ts_prev) ts_wide++;
            busy_left = 4;
            tx_busy = 1'b1;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) tx_busy = 1'b0;
        end
        ts_prev = tx_start;
        for (int c = 0; c < CH; c++) begin
            if (osc_rst[c]) rst_hi[c]++;
            if (osc_rst[c] && !rst_prev[c]) rst_rise[c]++;
        end
        rst_prev = osc_rst;
        if (meas_valid) mv_cnt++;
    end

    int nvec = 0, nfail = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] tapc(input int c);
        return tap[c*TW +: TW];
    endfunction

    task automatic send(input logic [7:0] b, input int wait_cyc);
        @(negedge clk); rx_valid = 1'b1; rx_byte = b;
        @(negedge clk); rx_valid = 1'b0;
        repeat (wait_cyc) @(negedge clk);
    endtask

    task automatic pop_tx(input string tag, input logic [8:0] exp);
        logic [8:0] v;
        v = (txq.size() > 0) ? {1'b0, txq.pop_front()} : 9'h1FF;
        chk(tag, 32'(v), 32'(exp));
    endtask

    task automatic pop_rng(input string tag, input logic [7:0] lo, input logic [7:0] hi);
        logic [8:0] v;
        v = (txq.size() > 0) ? {1'b0, txq.pop_front()} : 9'h1FF;
        chk(tag, 32'(v >= {1'b0, lo} && v <= {1'b0, hi}), 32'd1);
    endtask

    // Issues 'm' and returns the cycle offset at which meas_valid was seen.
    task automatic measure(output int n);
        @(negedge clk); rx_valid = 1'b1; rx_byte = 8'h6D;
        @(negedge clk); rx_valid = 1'b0;
        n = 1;
        while (meas_valid !== 1'b1 && n < GATE + 100) begin
            @(negedge clk); n++;
            if (n == 10) begin rx_valid = 1'b1; rx_byte = 8'h5D; end
            if (n == 11) rx_valid = 1'b0;
        end
    endtask

    int n, b_hi0, b_rise0, b_hi2, b_ts, b_mv, w;
    initial begin
        rst_n = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_oscrst", 32'(osc_rst), 32'hF);
        chk("rst_tap", 32'(tap), 32'h0);
        chk("rst_txstart", 32'(tx_start), 32'h0);
        chk("rst_meas", 32'(meas_count), 32'h0);
        chk("rst_mvalid", 32'(meas_valid), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_oscrst", 32'(osc_rst), 32'h0);
        b_hi0 = rst_hi[0]; b_rise0 = rst_rise[0]; b_hi2 = rst_hi[2];

        // first ']' with register timing check
        @(negedge clk); rx_valid = 1'b1; rx_byte = 8'h5D;
        @(negedge clk); rx_valid = 1'b0;
        chk("tap_lat", 32'(tapc(0)), 32'h1);
        chk("oscrst_lat", 32'(osc_rst), 32'h1);
        chk("tx_early", 32'(ts_cnt), 32'h0);
        repeat (20) @(negedge clk);
        send(8'h5D, 20); send(8'h5D, 20);
        pop_tx("echo_inc1", 9'h22); pop_tx("echo_inc2", 9'h23); pop_tx("echo_inc3", 9'h24);
        chk("tap0_3", 32'(tapc(0)), 32'h3);
        chk("oscrst0_hi", 32'(rst_hi[0] - b_hi0), 32'd3);
        chk("oscrst0_rise", 32'(rst_rise[0] - b_rise0), 32'd3);
        chk("others_tap", 32'(tap[CH*TW-1:TW]), 32'h0);
        chk("others_rst", 32'(rst_hi[2] - b_hi2), 32'd0);

        // saturation
        send(8'h72, 20); pop_tx("echo_r", 9'h21);
        send(8'h5B, 20); pop_tx("echo_dec0", 9'h21);
        chk("tap_floor", 32'(tapc(0)), 32'h0);
        for (int i = 0; i < 17; i++) send(8'h5D, 20);
        chk("echo_cnt17", 32'(txq.size()), 32'd17);
        while (txq.size() > 1) void'(txq.pop_front());
        pop_tx("echo_sat", 9'h30);
        chk("tap_ceil", 32'(tapc(0)), 32'hF);

        // channel select
        send(8'h32, 20); pop_tx("echo_sel2", 9'h32);
        send(8'h5D, 20); pop_tx("echo_ch2", 9'h22);
        chk("tap2", 32'(tapc(2)), 32'h1);
        chk("tap0_keep", 32'(tapc(0)), 32'hF);
        send(8'h37, 20);
        chk("sel7_noecho", 32'(txq.size()), 32'd0);
        send(8'h5D, 20); pop_tx("echo_sel_kept", 9'h23);
        chk("tap2_b", 32'(tapc(2)), 32'h2);

        // measurement on channel 1: 100 MHz / 16 over 1000 cycles at 32 MHz = 195.3
        send(8'h31, 20); pop_tx("echo_sel1", 9'h31);
        measure(n);
        chk("mv_latency", 32'(n), 32'(GATE + 1));
        chk("meas_range", 32'(meas_count >= 194 && meas_count <= 196), 32'd1);
        w = 0;
        while (w < 200) begin @(negedge clk); w++; end
        chk("gate_tap_drop", 32'(tapc(1)), 32'h0);
`ifdef RINGOSC_MON_HEX_EN
        chk("send_len", 32'(txq.size()), 32'd7);
        pop_tx("hex0", 9'h30); pop_tx("hex1", 9'h30); pop_tx("hex2", 9'h30);
        pop_tx("hex3", 9'h30); pop_tx("hex4", 9'h43);
        pop_rng("hex5", 8'h32, 8'h34);
        pop_tx("hex_nl", 9'h0A);
`else
        chk("send_len", 32'(txq.size()), 32'd3);
        pop_tx("bin0", 9'h00); pop_tx("bin1", 9'h00);
        pop_rng("bin2", 8'hC2, 8'hC4);
`endif

        // abort mid-SEND
        measure(n);
        chk("mv_latency2", 32'(n), 32'(GATE + 1));
        b_ts = ts_cnt; w = 0;
        while (ts_cnt == b_ts && w < 50) begin @(negedge clk); w++; end
        chk("send_started", 32'(ts_cnt - b_ts), 32'd1);
        rst_n = 1'b0; repeat (2) @(negedge clk); rst_n = 1'b1;
        b_ts = ts_cnt;
        repeat (100) @(negedge clk);
        chk("abort_send_tx", 32'(ts_cnt - b_ts), 32'd0);
        txq.delete();
        send(8'h5D, 20); pop_tx("idle_after_abort", 9'h22);

        // abort mid-GATE
        @(negedge clk); rx_valid = 1'b1; rx_byte = 8'h6D;
        @(negedge clk); rx_valid = 1'b0;
        repeat (200) @(negedge clk);
        rst_n = 1'b0; repeat (2) @(negedge clk); rst_n = 1'b1;
        b_ts = ts_cnt; b_mv = mv_cnt;
        repeat (GATE + 200) @(negedge clk);
        chk("abort_gate_mv", 32'(mv_cnt - b_mv), 32'd0);
        chk("abort_gate_tx", 32'(ts_cnt - b_ts), 32'd0);
        chk("txstart_1cyc", 32'(ts_wide), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/ringosc_freq_monitor.md
# ringosc_freq_monitor

- Command/measurement controller for a bank of adjustable ring oscillators.
- Decodes single-byte UART commands to select a channel, step its tap setting and reset it.
- Measures the selected oscillator's frequency against the system clock and reports the edge count back over UART.
- Sits between the `uart` block and `CHANNELS` instances of `ringoscillator_adjustable`, replacing the ad-hoc tap logic of the test top level.

## Interface
- `CHANNELS`, 4: number of oscillator channels, 1..10.
- `MAX_TAPS`, 16: tap range per channel, 0..MAX_TAPS-1. `TAP_W` = $clog2(MAX_TAPS) (derived).
- `PRESCALE_BITS`, 4: width of the per-channel oscillator-domain divider.
- `GATE_CYCLES`, 32000: measurement window in clk cycles (1 ms at 32 MHz).
- `COUNT_W`, 24: measurement counter width, multiple of 8.

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `osc_in`  in  CHANNELS: ring oscillator outputs, asynchronous to clk.
- `osc_rst`  out  CHANNELS: per-channel oscillator reset.
- `tap`  out  CHANNELS*TAP_W: packed tap selects; channel c at [c*TAP_W +: TAP_W].
- `rx_valid`  in  1: one-cycle pulse, byte received.
- `rx_byte`  in  8: received byte, valid with rx_valid.
- `tx_start`  out  1: one-cycle transmit request.
- `tx_byte`  out  8: byte to send, valid while tx_start is high.
- `tx_busy`  in  1: UART transmitter busy.
- `meas_count`  out  COUNT_W: last completed measurement.
- `meas_valid`  out  1: one-cycle pulse when meas_count updates.

## Operation
Commands are accepted only in IDLE; bytes arriving in any other state are dropped. Unknown bytes are ignored with no echo.
- `]` (0x5D): tap[sel] increments, saturating at MAX_TAPS-1. Pulses osc_rst[sel]. Echoes 0x21+newtap.
- `[` (0x5B): tap[sel] decrements, saturating at 0. Pulses osc_rst[sel]. Echoes 0x21+newtap.
- `r` (0x72): tap[sel] is set to 0. Pulses osc_rst[sel]. Echoes 0x21.
- `0`..`9` (0x30+c): if c<CHANNELS, sel=c and echo 0x30+c; otherwise ignored.
- `m` (0x6D): starts a measurement on channel sel.

Measurement path:
- Each channel has a PRESCALE_BITS ripple divider clocked by osc_in[c], cleared by osc_rst[c].
- The divider MSB passes through a 2-FF synchronizer into clk, then a rising-edge detector.
- The edge counter saturates at all-ones; it does not wrap.
- Frequency = count·2^PRESCALE_BITS·f_clk/GATE_CYCLES.

FSM states:
- IDLE: decodes commands as above.
- ECHO: sends one byte, then returns to IDLE.
- GATE: clears the counter, runs a clk down-counter of exactly GATE_CYCLES, then latches meas_count and moves to SEND.
- SEND: sends COUNT_W/8 bytes MSB first, then returns to IDLE.

Transmit handshake (per byte):
- Wait for tx_busy=0, then issue a one-cycle tx_start.
- Wait for tx_busy=1, then for tx_busy=0, before the next byte or return to IDLE.

## Timing
Reset values:
- tap=0 on all channels, sel=0, state IDLE.
- tx_start=0, tx_byte=0, meas_count=0, meas_valid=0.
- osc_rst is all ones while rst_n is low and all zeros from the first clk edge after release.

Tap commands:
- tap and osc_rst[sel] are registered: both update the cycle after rx_valid. osc_rst is high for exactly one cycle.
- tx_start rises no earlier than 2 cycles after rx_valid.

Measurement:
- `m` sampled at cycle T: counter is cleared at T+1, and edges are counted during cycles T+1..T+GATE_CYCLES.
- meas_valid pulses and meas_count updates at T+GATE_CYCLES+1.
- The first tx_start comes no earlier than the following cycle.

Boundary conditions:
- rx_valid in the same cycle the FSM returns to IDLE is dropped.
- Asserting rst_n low mid-GATE or mid-SEND aborts: no further tx_start and no meas_valid.
- Only one channel's divider is observed; other channels keep running.

## Configuration
- `RINGOSC_MON_HEX_EN` defined: SEND emits COUNT_W/4 uppercase ASCII hex digits, MSB first, then 0x0A.
- Undefined: SEND emits COUNT_W/8 raw binary bytes, MSB first.
- Command decode, echo bytes and measurement are identical in both builds.

## Test plan
- Reset: hold rst_n low, then release. Required: osc_rst=all ones during reset and 0 one cycle after release; all taps 0; tx_start never asserts.
- Send `]`×3 on channel 0 with a UART model driving tx_busy. Required: tap0=3; echoes 0x22, 0x23, 0x24; three single-cycle osc_rst[0] pulses; other channels untouched.
- Saturation:
  - `[` at tap 0 → tap stays 0, echo 0x21.
  - 17×`]` (MAX_TAPS=16) → tap=15, final echo 0x30.
- Channel select with CHANNELS=4:
  - `2` then `]` → echo 0x32, tap[2]=1, tap[0] unchanged.
  - `7` → no echo, sel unchanged.
- Measurement, binary build, GATE_CYCLES=1000, clk 32 MHz, osc_in[1]=100 MHz async:
  - `1`, `m` → meas_count=195±1.
  - Bytes 0x00, 0x00, 0xC3±1.
  - A `]` sent mid-gate is dropped (tap[1] unchanged, no echo).
- Hex build, same stimulus → "0000C3"±1 followed by 0x0A. Separately, rst_n pulsed mid-SEND → no further tx_start, state IDLE.
